score_display: RTL and testbench

Eight-digit seven-segment scoreboard downstream of the breakout game core. It consumes the 9-bit current score and the game-over flag, and keeps a high-score register. It converts both values to BCD with one shared sequential double-dabble converter and time-multiplexes them onto the board's 7-segment anodes. It drives the `seg`/`AN` outputs that the top level leaves unconnected today.

---
 rtl/score_pkg.sv | 46 ++++
 rtl/score_display_bin2bcd.sv | 63 ++++++
 rtl/score_display.sv | 170 +++++++++++++++++
 tb/tb_score_display.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants for the scoreboard display: score width,
// active-low segment glyphs and converter FSM states.
package score_pkg;

  localparam int SCORE_W = 9;
  localparam int BCD_W   = 12;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CUR  = 2'd1,
    HI   = 2'd2
  } state_t;

  function automatic logic [6:0] seg_glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    unique case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble converter: one load cycle,
// then W add-3/shift iterations, done pulsed after the last.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int W = SCORE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [W-1:0]     i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]     r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_display.sv
// Scoreboard: high-score register, shared BCD conversion, 8-digit scan.
// SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros per 3-digit group.
module score_display
  import score_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               endgame,
  output logic [6:0]         seg,
  output logic [7:0]         AN
);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;

  state_t             r_state;
  logic               r_start;
  logic               r_eg_d;
  logic [SCORE_W-1:0] r_hi;
  logic [SCORE_W-1:0] r_cur_last;
  logic [SCORE_W-1:0] r_hi_last;
  logic [BCD_W-1:0]   r_cur_bcd;
  logic [BCD_W-1:0]   r_hi_bcd;
  logic [TW-1:0]      r_tick;
  logic [2:0]         r_dig;
  logic [6:0]         r_seg;
  logic [7:0]         r_an;

  logic [SCORE_W-1:0] w_operand;
  logic               w_busy;
  logic               w_done;
  logic [BCD_W-1:0]   w_bcd;
  logic               w_eg_rise;
  logic [3:0]         w_nib;
  logic               w_blank;
  logic [6:0]         w_glyph;

  assign w_eg_rise = endgame && !r_eg_d;
  assign w_operand = (r_state == HI) ? r_hi_last : r_cur_last;

  bin2bcd_seq #(.W(SCORE_W)) u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_bin   (w_operand),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eg_d <= 1'b0;
      r_hi   <= '0;
    end else begin
      r_eg_d <= endgame;
      if (w_eg_rise && (score > r_hi))
        r_hi <= score;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_cur_last <= '0;
      r_hi_last  <= '0;
      r_cur_bcd  <= '0;
      r_hi_bcd   <= '0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_busy && (score != r_cur_last)) begin
            r_cur_last <= score;
            r_start    <= 1'b1;
            r_state    <= CUR;
          end else if (!w_busy && (r_hi != r_hi_last)) begin
            r_hi_last <= r_hi;
            r_start   <= 1'b1;
            r_state   <= HI;
          end
        end
        CUR: begin
          if (w_done) begin
            r_cur_bcd <= w_bcd;
            if (r_hi != r_hi_last) begin
              r_hi_last <= r_hi;
              r_start   <= 1'b1;
              r_state   <= HI;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        HI: begin
          if (w_done) begin
            r_hi_bcd <= w_bcd;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Leading-zero blanking collapses to constants when LZ is 0
  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b1;
    case (r_dig)
      3'd0: begin
        w_nib   = r_cur_bcd[3:0];
        w_blank = 1'b0;
      end
      3'd1: begin
        w_nib   = r_cur_bcd[7:4];
        w_blank = LZ && (r_cur_bcd[11:4] == 8'd0);
      end
      3'd2: begin
        w_nib   = r_cur_bcd[11:8];
        w_blank = LZ && (r_cur_bcd[11:8] == 4'd0);
      end
      3'd4: begin
        w_nib   = r_hi_bcd[3:0];
        w_blank = 1'b0;
      end
      3'd5: begin
        w_nib   = r_hi_bcd[7:4];
        w_blank = LZ && (r_hi_bcd[11:4] == 8'd0);
      end
      3'd6: begin
        w_nib   = r_hi_bcd[11:8];
        w_blank = LZ && (r_hi_bcd[11:8] == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase
    w_glyph = w_blank ? SEG_BLANK : seg_glyph(w_nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_dig  <= 3'd0;
      r_seg  <= SEG_BLANK;
      r_an   <= 8'hFF;
    end else begin
      if (r_tick == TW'(DIGIT_TICKS - 1)) begin
        r_tick <= '0;
        r_dig  <= r_dig + 3'd1;
      end else begin
        r_tick <= r_tick + TW'(1);
      end
      r_seg <= w_glyph;
      r_an  <= ~(8'b1 << r_dig);
    end
  end

  assign seg = r_seg;
  assign AN  = r_an;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display (DIGIT_TICKS=4).
module tb_score_display;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] score = '0;
  logic       endgame = 1'b0;
  logic [6:0] seg;
  logic [7:0] AN;

  int errors = 0;
  int checks = 0;

  logic [11:0] q_cur[$];
  logic [11:0] q_hi[$];
  logic [11:0] exp_v;
  logic [6:0]  seen[8];
  bit          scan_bad;
  bit          got;

  score_display #(.DIGIT_TICKS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .score   (score),
    .endgame (endgame),
    .seg     (seg),
    .AN      (AN)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(
    input logic [11:0] b, input int p
  );
    logic [3:0] h, t, o;
    h = b[11:8];
    t = b[7:4];
    o = b[3:0];
    case (p)
      0: return glyph(o);
      1: return (LZ && h == 0 && t == 0) ? 7'h7F : glyph(t);
      2: return (LZ && h == 0) ? 7'h7F : glyph(h);
      default: return 7'h7F;
    endcase
  endfunction

  task automatic wait_cur(input int budget, output bit ok);
    logic [11:0] prev;
    prev = dut.r_cur_bcd;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.r_cur_bcd !== prev) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_hi(input int budget, output bit ok);
    logic [11:0] prev;
    prev = dut.r_hi_bcd;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.r_hi_bcd !== prev) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic scan_capture();
    bit hit;
    scan_bad = 1'b0;
    for (int k = 0; k < 8; k++) seen[k] = 7'h55;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hit = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (AN == ~(8'h01 << k)) begin
          seen[k] = seg;
          hit = 1'b1;
        end
      end
      if (!hit) scan_bad = 1'b1;
    end
  endtask

  task automatic test_scan(input string nm);
    logic [11:0] c, h;
    logic [6:0]  e;
    c = q_cur.size() > 0 ? q_cur[$] : 12'h0;
    h = q_hi.size() > 0 ? q_hi[$] : 12'h0;
    c = exp_v;
    h = (nm == "scan123") ? 12'h000 : 12'h045;
    scan_capture();
    checks++;
    if (scan_bad) begin
      errors++;
      $display("FAIL %s AN not one-hot-low while scanning", nm);
    end
    for (int k = 0; k < 8; k++) begin
      e = (k < 4) ? exp_digit(c, k) : exp_digit(h, k - 4);
      checks++;
      if (seen[k] !== e) begin
        errors++;
        $display("FAIL %s digit%0d seg=%h exp=%h", nm, k, seen[k], e);
      end
    end
  endtask

  task automatic pop_cur(input string nm, input int budget);
    wait_cur(budget, got);
    exp_v = q_cur.pop_front();
    checks++;
    if (!got || dut.r_cur_bcd !== exp_v) begin
      errors++;
      $display("FAIL %s cur_bcd=%h exp=%h changed=%0d",
               nm, dut.r_cur_bcd, exp_v, got);
    end
  endtask

  task automatic pop_hi(input string nm, input int budget);
    logic [11:0] e;
    wait_hi(budget, got);
    e = q_hi.pop_front();
    checks++;
    if (!got || dut.r_hi_bcd !== e) begin
      errors++;
      $display("FAIL %s hi_bcd=%h exp=%h changed=%0d",
               nm, dut.r_hi_bcd, e, got);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL rst_seg seg=%h exp=7f", seg);
    end
    if (AN !== 8'hFF) begin
      errors++; $display("FAIL rst_an AN=%h exp=ff", AN);
    end
    if (dut.r_hi !== 9'd0) begin
      errors++; $display("FAIL rst_hi hi=%0d exp=0", dut.r_hi);
    end
    if (dut.r_cur_bcd !== 12'h0) begin
      errors++; $display("FAIL rst_cur cur=%h exp=0", dut.r_cur_bcd);
    end
    if (dut.r_hi_bcd !== 12'h0) begin
      errors++; $display("FAIL rst_hib hi_bcd=%h exp=0", dut.r_hi_bcd);
    end
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (AN !== 8'hFE) begin
      errors++; $display("FAIL first_an AN=%h exp=fe", AN);
    end
    if (seg !== 7'h40) begin
      errors++; $display("FAIL first_seg seg=%h exp=40", seg);
    end
  endtask

  task automatic test_cur123();
    score = 9'd123;
    q_cur.push_back(12'h123);
    pop_cur("cur123", 24);
    exp_v = 12'h123;
    test_scan("scan123");
  endtask

  task automatic test_hiscore();
    score = 9'd45;
    q_cur.push_back(12'h045);
    pop_cur("cur45", 24);
    endgame = 1'b1;
    q_hi.push_back(12'h045);
    @(negedge clk);
    checks++;
    if (dut.r_hi !== 9'd45) begin
      errors++; $display("FAIL hi45 hi=%0d exp=45", dut.r_hi);
    end
    pop_hi("hib45", 24);
    endgame = 1'b0;
    repeat (2) @(negedge clk);
    score = 9'd30;
    repeat (2) @(negedge clk);
    endgame = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dut.r_hi !== 9'd45) begin
      errors++; $display("FAIL hi_lower hi=%0d exp=45", dut.r_hi);
    end
    score = 9'd60;
    repeat (3) @(negedge clk);
    checks++;
    if (dut.r_hi !== 9'd45) begin
      errors++; $display("FAIL hi_held hi=%0d exp=45", dut.r_hi);
    end
    endgame = 1'b0;
    repeat (40) @(negedge clk);
    checks += 2;
    if (dut.r_cur_bcd !== 12'h060) begin
      errors++; $display("FAIL cur60 cur=%h exp=060", dut.r_cur_bcd);
    end
    if (dut.r_hi_bcd !== 12'h045) begin
      errors++; $display("FAIL hib_keep hi_bcd=%h exp=045", dut.r_hi_bcd);
    end
  endtask

  task automatic test_leading();
    score = 9'd7;
    q_cur.push_back(12'h007);
    pop_cur("cur7", 24);
    exp_v = 12'h007;
    test_scan("scan7");
  endtask

  task automatic test_max();
    score = 9'd511;
    q_cur.push_back(12'h511);
    pop_cur("cur511", 24);
    endgame = 1'b1;
    q_hi.push_back(12'h511);
    @(negedge clk);
    checks++;
    if (dut.r_hi !== 9'd511) begin
      errors++; $display("FAIL hi511 hi=%0d exp=511", dut.r_hi);
    end
    pop_hi("hib511", 24);
    endgame = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    score = 9'd100;
    q_cur.push_back(12'h100);
    repeat (4) @(negedge clk);
    score = 9'd200;
    q_cur.push_back(12'h200);
    pop_cur("b2b_first", 24);
    pop_cur("b2b_second", 24);
  endtask

  task automatic test_reset_mid_hi();
    rst = 1'b1;
    score = 9'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    score = 9'd50;
    endgame = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.r_hi !== 9'd50) begin
      errors++; $display("FAIL hi_same_edge hi=%0d exp=50", dut.r_hi);
    end
    repeat (16) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL mid_seg seg=%h exp=7f", seg);
    end
    if (AN !== 8'hFF) begin
      errors++; $display("FAIL mid_an AN=%h exp=ff", AN);
    end
    if (dut.r_hi !== 9'd0) begin
      errors++; $display("FAIL mid_hi hi=%0d exp=0", dut.r_hi);
    end
    if (dut.r_cur_bcd !== 12'h0) begin
      errors++; $display("FAIL mid_cur cur=%h exp=0", dut.r_cur_bcd);
    end
    if (dut.r_hi_bcd !== 12'h0) begin
      errors++; $display("FAIL mid_hib hi_bcd=%h exp=0", dut.r_hi_bcd);
    end
    score = 9'd0;
    endgame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (AN !== 8'hFE) begin
      errors++; $display("FAIL restart_an AN=%h exp=fe", AN);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (dut.r_hi_bcd !== 12'h0) begin
      errors++; $display("FAIL post_hib hi_bcd=%h exp=0", dut.r_hi_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_cur123();
    test_hiscore();
    test_leading();
    test_max();
    test_back_to_back();
    test_reset_mid_hi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
